// File: rtl/board_move_decoder.sv
// rtl/board_move_decoder.sv - recovers the blank move between a parent/child 3x3 puzzle board pair
//
// Purpose:
//   Takes a parent/child pair of 40-bit boards and determines which blank move
//   (UP/DOWN/RIGHT/LEFT) turns the parent into the child. It reports whether the
//   pair is exactly one legal move, which tile slid, and a saturating count of
//   the legal results that have been consumed.
//   Board layout: [39:36] blank position (0..8, row-major), tile k at [35-4k:32-4k].
//
// Configuration macro:
//   MOVE_DEC_STRICT_EN - defined: every tile is compared against the expected
//                        swap, one tile per cycle (10-cycle latency).
//                        undefined: geometry only (1-cycle latency).
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   parent/child pair offered
//   in_ready   out  1   block can accept a pair (IDLE only)
//   parent     in  40   board before the move
//   child      in  40   board after the move
//   out_valid  out  1   result available
//   out_ready  in   1   consumer takes result
//   dir        out  2   0=UP 1=DOWN 2=RIGHT 3=LEFT (blank movement)
//   legal      out  1   pair is exactly one legal move
//   moved_tile out  4   parent tile at the child blank position
//   move_cnt   out 16   legal results consumed since reset, saturating

module board_move_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] parent,
  input  logic [39:0] child,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dir,
  output logic        legal,
  output logic [3:0]  moved_tile,
  output logic [15:0] move_cnt
);

`ifdef MOVE_DEC_STRICT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`endif

  // Tile k of a board; indices beyond the grid read as zero.
  function automatic logic [3:0] tile_at(input logic [39:0] b, input logic [3:0] k);
    case (k)
      4'd0:    tile_at = b[35:32];
      4'd1:    tile_at = b[31:28];
      4'd2:    tile_at = b[27:24];
      4'd3:    tile_at = b[23:20];
      4'd4:    tile_at = b[19:16];
      4'd5:    tile_at = b[15:12];
      4'd6:    tile_at = b[11:8];
      4'd7:    tile_at = b[7:4];
      4'd8:    tile_at = b[3:0];
      default: tile_at = 4'd0;
    endcase
  endfunction

  // Returns {geom_ok, dir}. Widened to 5 bits so p-3 / p-1 cannot wrap.
  function automatic logic [2:0] geom(input logic [3:0] p, input logic [3:0] c);
    logic [4:0] p5;
    logic [4:0] c5;
    logic [1:0] pm3;
    logic [2:0] res;
    p5 = {1'b0, p};
    c5 = {1'b0, c};
    case (p)
      4'd0, 4'd3, 4'd6: pm3 = 2'd0;
      4'd1, 4'd4, 4'd7: pm3 = 2'd1;
      default:          pm3 = 2'd2;
    endcase
    res = 3'b000;
    if (p <= 4'd8 && c <= 4'd8) begin
      if (c5 + 5'd3 == p5)                      res = 3'b100;
      else if (c5 == p5 + 5'd3)                 res = 3'b101;
      else if (c5 == p5 + 5'd1 && pm3 != 2'd2)  res = 3'b110;
      else if (c5 + 5'd1 == p5 && pm3 != 2'd0)  res = 3'b111;
    end
    return res;
  endfunction

  state_t r_state;

`ifdef MOVE_DEC_STRICT_EN
  logic [39:0] r_parent;
  logic [39:0] r_child;
  logic [3:0]  r_k;
  logic        r_scan_ok;
  logic [3:0]  w_p;
  logic [3:0]  w_c;
  logic [3:0]  w_exp_idx;
  logic        w_tile_match;
  logic [2:0]  w_geom;
  logic        w_scan_final;

  assign w_p    = r_parent[39:36];
  assign w_c    = r_child[39:36];
  assign w_geom = geom(w_p, w_c);

  // Expected source of child tile k: the two blank positions trade places,
  // every other tile must be unchanged.
  assign w_exp_idx    = (r_k == w_c) ? w_p : ((r_k == w_p) ? w_c : r_k);
  assign w_tile_match = (tile_at(r_child, r_k) == tile_at(r_parent, w_exp_idx));
  assign w_scan_final = r_scan_ok & w_tile_match;
`else
  logic [2:0] w_geom_in;
  logic       w_unused_child;

  assign w_geom_in      = geom(parent[39:36], child[39:36]);
  // Child tiles are not inspected in the geometry-only build.
  assign w_unused_child = ^child[35:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      dir        <= 2'd0;
      legal      <= 1'b0;
      moved_tile <= 4'd0;
      move_cnt   <= 16'd0;
`ifdef MOVE_DEC_STRICT_EN
      r_parent   <= 40'd0;
      r_child    <= 40'd0;
      r_k        <= 4'd0;
      r_scan_ok  <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifdef MOVE_DEC_STRICT_EN
            r_parent  <= parent;
            r_child   <= child;
            r_k       <= 4'd0;
            r_scan_ok <= 1'b1;
            r_state   <= ST_SCAN;
`else
            r_state    <= ST_DONE;
            out_valid  <= 1'b1;
            legal      <= w_geom_in[2];
            dir        <= w_geom_in[2] ? w_geom_in[1:0] : 2'd0;
            moved_tile <= w_geom_in[2] ? tile_at(parent, child[39:36]) : 4'd0;
`endif
          end
        end
`ifdef MOVE_DEC_STRICT_EN
        ST_SCAN: begin
          r_scan_ok <= w_scan_final;
          if (r_k == 4'd8) begin
            r_state    <= ST_DONE;
            out_valid  <= 1'b1;
            legal      <= w_geom[2] & w_scan_final;
            dir        <= w_geom[2] ? w_geom[1:0] : 2'd0;
            moved_tile <= w_geom[2] ? tile_at(r_parent, w_c) : 4'd0;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            if (legal && move_cnt != 16'hFFFF) begin
              move_cnt <= move_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_move_decoder.sv
// tb/tb_board_move_decoder.sv - self-checking bench for board_move_decoder

module tb_board_move_decoder;

`ifdef MOVE_DEC_STRICT_EN
  localparam int LAT = 10;
  localparam bit STRICT = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit STRICT = 1'b0;
`endif

  localparam logic [39:0] UP_P   = 40'h4_123405678;
  localparam logic [39:0] UP_C   = 40'h1_103425678;
  localparam logic [39:0] RT_C   = 40'h5_123450678;
  localparam logic [39:0] WRAP_P = 40'h2_120345678;
  localparam logic [39:0] WRAP_C = 40'h3_123045678;
  localparam logic [39:0] BAD_C  = 40'h1_10342567F;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] parent;
  logic [39:0] child;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dir;
  logic        legal;
  logic [3:0]  moved_tile;
  logic [15:0] move_cnt;

  board_move_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .parent     (parent),
    .child      (child),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dir        (dir),
    .legal      (legal),
    .moved_tile (moved_tile),
    .move_cnt   (move_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: blank moves between grid cells by row/column arithmetic, and a
  // legal child equals the parent with the two blank cells' tiles exchanged.
  function automatic void model(input logic [39:0] pb, input logic [39:0] cb,
                                output logic lg, output logic [1:0] d, output logic [3:0] t);
    int p;
    int c;
    bit g;
    bit same;
    logic [3:0] pt[9];
    logic [3:0] ct[9];
    logic [3:0] et[9];
    p = int'(pb[39:36]);
    c = int'(cb[39:36]);
    g = 1'b0;
    d = 2'd0;
    for (int k = 0; k < 9; k++) begin
      pt[k] = pb[35-4*k -: 4];
      ct[k] = cb[35-4*k -: 4];
    end
    if (p <= 8 && c <= 8) begin
      if (c % 3 == p % 3 && c / 3 == p / 3 - 1)      begin g = 1'b1; d = 2'd0; end
      else if (c % 3 == p % 3 && c / 3 == p / 3 + 1) begin g = 1'b1; d = 2'd1; end
      else if (c / 3 == p / 3 && c % 3 == p % 3 + 1) begin g = 1'b1; d = 2'd2; end
      else if (c / 3 == p / 3 && c % 3 == p % 3 - 1) begin g = 1'b1; d = 2'd3; end
    end
    same = 1'b0;
    if (g) begin
      et = pt;
      et[c] = pt[p];
      et[p] = pt[c];
      same = (et == ct);
    end
    lg = STRICT ? (g && same) : g;
    t  = g ? pt[c] : 4'd0;
  endfunction

  // Cycle-level scoreboard: one outstanding pair, result visible LAT cycles
  // after the accept cycle, held until the handshake.
  bit         m_known = 1'b0;
  bit         m_busy  = 1'b0;
  int         m_acc   = 0;
  int         m_cnt   = 0;
  logic       m_lg;
  logic [1:0] m_dir;
  logic [3:0] m_tile;

  always @(negedge clk) begin
    bit exp_ov;
    exp_ov = m_busy && (cyc >= m_acc + LAT);
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("move_cnt", 32'(move_cnt), 32'(m_cnt));
      if (exp_ov) begin
        chk("dir", 32'(dir), 32'(m_dir));
        chk("legal", 32'(legal), 32'(m_lg));
        chk("moved_tile", 32'(moved_tile), 32'(m_tile));
      end
    end
    if (rst) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_cnt   = 0;
    end else if (!m_busy && in_valid) begin
      model(parent, child, m_lg, m_dir, m_tile);
      m_busy = 1'b1;
      m_acc  = cyc;
    end else if (exp_ov && out_ready) begin
      m_busy = 1'b0;
      if (m_lg && m_cnt < 65535) m_cnt++;
    end
  end

  // Offer a pair and wait (bounded) for the accept edge; returns at edge+1.
  task automatic offer(input logic [39:0] p, input logic [39:0] c, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    parent = p;
    child = c;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    parent = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
    child = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  // Directed pair with literal expectations and exact latency.
  task automatic run_lit(input string name, input logic [39:0] p, input logic [39:0] c,
                         input logic [1:0] ed, input logic el, input logic [3:0] et,
                         input int ecnt);
    bit ok;
    out_ready = 1'b1;
    offer(p, c, ok);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i < LAT) chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_dir"}, 32'(dir), 32'(ed));
    chk({name, "_legal"}, 32'(legal), 32'(el));
    chk({name, "_tile"}, 32'(moved_tile), 32'(et));
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_cnt"}, 32'(move_cnt), 32'(ecnt));
  endtask

  function automatic logic [39:0] pack(input logic [3:0] blank, input logic [3:0] t[9]);
    logic [39:0] b;
    b[39:36] = blank;
    for (int k = 0; k < 9; k++) b[35-4*k -: 4] = t[k];
    return b;
  endfunction

  initial begin
    bit ok;
    bit done;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    parent = 40'd0;
    child = 40'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_fields", {dir, legal, moved_tile}, 32'd0);
    chk("reset_cnt", 32'(move_cnt), 32'd0);

    run_lit("up", UP_P, UP_C, 2'd0, 1'b1, 4'd2, 1);
    run_lit("right", UP_P, RT_C, 2'd2, 1'b1, 4'd5, 2);
    run_lit("wrap", WRAP_P, WRAP_C, 2'd0, 1'b0, 4'd0, 2);
    run_lit("corrupt", UP_P, BAD_C, 2'd0, !STRICT, 4'd2, STRICT ? 2 : 3);

    // Backpressure: result held, new pair not taken until the handshake.
    out_ready = 1'b0;
    offer(UP_P, UP_C, ok);
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    if (!done) chk("bp_valid_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    parent = UP_P;
    child = RT_C;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", {out_valid, legal, dir, moved_tile}, {1'b1, 1'b1, 2'd0, 4'd2});
      if (i < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (out_valid) begin
        done = 1'b1;
        chk("bp_second_dir", 32'(dir), 32'd2);
      end
    end
    if (!done) chk("bp_second_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;

    // Reset in cycle A+4: the pending result is discarded.
    out_ready = 1'b0;
    offer(UP_P, UP_C, ok);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_cnt", 32'(move_cnt), 32'd0);
    out_ready = 1'b1;
    repeat (14) @(posedge clk);

    // Randomized pairs, mostly single-step moves with occasional corruption.
    for (int n = 0; n < 200; n++) begin
      logic [3:0] pt[9];
      logic [3:0] ct[9];
      logic [3:0] pblank;
      logic [3:0] cblank;
      int off;
      for (int k = 0; k < 9; k++) pt[k] = 4'($urandom_range(0, 15));
      pblank = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 3))
          0: off = -3;
          1: off = 3;
          2: off = 1;
          default: off = -1;
        endcase
        cblank = 4'(int'(pblank) + off);
      end else begin
        cblank = 4'($urandom_range(0, 15));
      end
      ct = pt;
      if (pblank <= 4'd8 && cblank <= 4'd8) begin
        ct[cblank] = pt[pblank];
        ct[pblank] = pt[cblank];
      end
      if ($urandom_range(0, 4) == 0) begin
        int ki;
        ki = $urandom_range(0, 8);
        ct[ki] = ct[ki] ^ 4'($urandom_range(1, 15));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      out_ready = 1'($urandom_range(0, 1));
      offer(pack(pblank, pt), pack(cblank, ct), ok);
      done = 1'b0;
      for (int t = 0; t < 80 && !done; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (out_valid && out_ready) done = 1'b1;
        @(posedge clk); #1;
      end
      if (!done) chk("rand_result_timeout", 32'd1, 32'd0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_move_decoder.md
# board_move_decoder

Inverse of the move-generation ALU operations. Takes a parent/child pair of 40-bit puzzle boards and recovers which blank move (UP/DOWN/RIGHT/LEFT) produced the child. Checks that the pair is a legal single move and reports the moved tile. Sits downstream of the search datapath and is used for solution-path replay and self-checking of TO_UP/TO_DOWN/TO_RIGHT/TO_LEFT results.

## Interface
- No parameters. Board format is fixed:
  - bits [39:36]: blank position, 0–8, row-major on a 3×3 grid.
  - tile k (k = 0..8) at bits [35-4k:32-4k].
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  parent/child pair offered
- in_ready  out  1  block can accept a pair
- parent  in  40  board before the move
- child  in  40  board after the move
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- dir  out  2  0=UP, 1=DOWN, 2=RIGHT, 3=LEFT (blank movement direction)
- legal  out  1  pair is exactly one legal move
- moved_tile  out  4  value of the tile that slid (parent tile at the child blank position)
- move_cnt  out  16  count of legal results consumed since reset

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid, latch parent and child, set p=parent[39:36] and c=child[39:36], clear the scan index k, and go to SCAN.
- Geometry is evaluated on the latched p and c. A pair is geometrically valid only if p≤8, c≤8, and one of the following holds:
  - c=p-3 → UP.
  - c=p+3 → DOWN.
  - c=p+1 with p mod 3 ≠ 2 → RIGHT.
  - c=p-1 with p mod 3 ≠ 0 → LEFT.
- If geometry is invalid: dir=0, moved_tile=0, legal=0.
- SCAN checks one tile per cycle, k = 0..8, and accumulates an ok flag:
  - k≠p and k≠c: requires child[k]==parent[k].
  - k==c: requires child[c]==parent[p].
  - k==p: requires child[p]==parent[c].
- moved_tile = parent[c].
- After k=8, go to DONE with legal = geom_ok & scan_ok.
- DONE: out_valid=1, and all outputs are held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - If legal=1 on that handshake, move_cnt increments; it saturates at 16'hFFFF.
- in_ready is 1 only in IDLE. There is no overlap between consecutive pairs.
- In SCAN and DONE, changes on parent, child or in_valid are ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, dir=0, legal=0, moved_tile=0, move_cnt=0, FSM in IDLE.
- Accept happens in cycle A (in_valid & in_ready at the clock edge).
- The SCAN phase covers cycles A+1 through A+9.
- out_valid rises in cycle A+10, so latency is 10 cycles.
- Back-to-back throughput: one pair per 11 cycles when out_ready is held at 1.
- out_ready may be high before out_valid; the handshake still completes in the first DONE cycle.
- rst asserted in any state returns the block to IDLE at the next edge with reset values, and the pending result is discarded. move_cnt is cleared.
- In IDLE, out_ready has no effect.

## Configuration
- MOVE_DEC_STRICT_EN
  - Defined: full tile scan as above; latency 10 cycles.
  - Undefined: the SCAN state is removed.
    - DONE is entered in cycle A+1, so latency is 1 cycle.
    - legal = geom_ok only.
    - moved_tile = parent[c] is still reported.

## Test plan
- Legal UP:
  - Stimulus: parent=40'h4_123405678, child=40'h1_103425678.
  - Required response: dir=0, legal=1, moved_tile=2, out_valid exactly 10 cycles after accept, move_cnt=1 after handshake.
- Legal RIGHT:
  - Stimulus: parent=40'h4_123405678, child=40'h5_123450678.
  - Required response: dir=2, legal=1, moved_tile=5.
- Row-wrap rejection:
  - Stimulus: parent=40'h2_120345678, child=40'h3_123045678.
  - Required response: legal=0, dir=0, moved_tile=0, move_cnt unchanged.
- Corrupted tile:
  - Stimulus: the UP pair, but with child tile 8 changed to 4'hF.
  - Required response: legal=0 with MOVE_DEC_STRICT_EN defined; legal=1 and latency 1 without it.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises.
  - Required response: outputs stable throughout, in_ready=0, and a new in_valid is not accepted until after the handshake.
- Reset mid-SCAN:
  - Stimulus: assert rst at A+4.
  - Required response: next cycle in_ready=1, out_valid=0, move_cnt=0, and no result is produced.
